dcache_if_initiator: RTL
========================

// Module: dcache_if_initiator
// PURPOSE
//  Requester side of the split index/tag data-memory interface (req/gnt, tag phase, rvalid).
//  Takes load/store ops from the LSU over valid/ready and issues them to the D$ or memory mock.
//  Tracks outstanding requests in order and returns one response per non-killed request.
//  Sits between the LSU address stage and the data memory port.
// PARAMETERS
//  NR_OUTSTANDING  2   max requests granted but not yet answered by rvalid (>=1)
//  INDEX_WIDTH     12  index field = addr[INDEX_WIDTH-1:0]
//  TAG_WIDTH       44  tag field = addr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH]; addr[63:56] ignored
// PORTS
//  clk_i                   in   1   clock
//  rst_i                   in   1   asynchronous reset, active high
//  lsu_req_valid_i         in   1   LSU op valid
//  lsu_req_ready_o         out  1   op accepted when valid&ready
//  lsu_addr_i              in   64  byte address
//  lsu_we_i                in   1   1 = store, 0 = load
//  lsu_be_i                in   8   byte enables
//  lsu_wdata_i             in   64  store data
//  lsu_kill_i              in   1   kill the op currently in tag phase (loads only)
//  lsu_resp_valid_o        out  1   response valid, one cycle pulse
//  lsu_resp_we_o           out  1   response belongs to a store (ack)
//  lsu_resp_rdata_o        out  64  load data
//  data_if_address_index_o out  12  index, valid with req
//  data_if_address_tag_o   out  44  tag, valid with tag_valid
//  data_if_data_wdata_o    out  64  store data, valid with req
//  data_if_data_req_o      out  1   request
//  data_if_data_we_o       out  1   write enable
//  data_if_data_be_o       out  8   byte enables
//  data_if_kill_req_o      out  1   abort request in tag phase
//  data_if_tag_valid_o     out  1   tag phase valid
//  data_if_data_gnt_i      in   1   grant
//  data_if_data_rvalid_i   in   1   response valid
//  data_if_data_rdata_i    in   64  response data
//  err_o                   out  1   sticky protocol error
// BEHAVIOUR
//  Reset: all outputs 0; issue/tag stages empty; outstanding FIFO empty; err_o=0. Reset mid-op drops everything.
//  Issue stage: 1-entry register. lsu_req_ready_o = !issue_valid_q | (data_req_o & gnt_i).
//  Issue rule: data_req_o = issue_valid_q & (count < NR_OUTSTANDING).
//  While req is high without gnt, index/we/be/wdata stay stable.
//  Grant: on req&gnt, push {we, killed=0} to the FIFO and move {tag, we} to the tag stage.
//  The tag stage holds exactly the next cycle. A new op may be granted in that same cycle (full pipelining).
//  Tag cycle, normal: tag_valid_o=1, tag_o=stored tag, kill_req_o=0.
//  Tag cycle, load with lsu_kill_i=1: kill_req_o=1, tag_valid_o=0, youngest FIFO entry marked killed.
//  Tag cycle, store: lsu_kill_i is ignored; the tag is always sent.
//  Response: rvalid pops the FIFO head. lsu_resp_valid_o is registered, 1 cycle after rvalid, with rdata and head.we.
//  Response is suppressed if head.killed. It is also suppressed if head is the tag-stage entry being killed this cycle.
//  Latency (gnt in issue cycle, responder rvalid = gnt+1):
//    accept at cycle N -> req at N+1 -> tag at N+2 -> resp_valid at N+3.
//  Count: push and pop in the same cycle leaves count unchanged. count saturates at NR_OUTSTANDING (no req issued).
//  rvalid with count==0: ignored, err_o <= 1, stays set until reset.
//  FIFO pointers wrap modulo NR_OUTSTANDING; responses are strictly in issue order.
// TESTING
//  1 load addr=0x8000_1238, gnt same cycle, rvalid+1 rdata=0xDEADBEEF00001234
//    -> index=0x238 at c1, tag=0x80001 at c2 with tag_valid=1, resp_valid c3 with that data, we=0.
//  2 store be=0x0F wdata=0x11223344 -> req c1 with we=1/be=0x0F/wdata, tag c2, resp_valid c3 with resp_we=1.
//  3 4 back-to-back loads, gnt=1, rvalid 3 cycles after gnt, N=2
//    -> req drops when count=2; 4 in-order responses, none lost.
//  4 load killed in tag cycle, rvalid same cycle
//    -> kill_req=1, tag_valid=0, no resp_valid; next load answered normally.
//  5 gnt held low 3 cycles -> req/index/be/wdata stable, ready=0, no tag phase; gnt on 4th -> tag next cycle.
//  6 rvalid with nothing outstanding -> err_o=1 sticky; assert rst_i mid-flight -> all outputs 0, err_o=0.

Source files
------------

// File: rtl/dcache_if_initiator.sv
// dcache_if_initiator
// Requester side of the split index/tag data-memory interface. Accepts LSU
// load/store ops into a one-entry issue stage, issues the index phase with
// req/gnt, sends the tag (or a kill) the cycle after the grant, and returns one
// registered response per non-killed request, strictly in issue order.

module dcache_if_initiator #(
    parameter int unsigned NR_OUTSTANDING = 2,
    parameter int unsigned INDEX_WIDTH    = 12,
    parameter int unsigned TAG_WIDTH      = 44
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lsu_req_valid_i,
    output logic                   lsu_req_ready_o,
    input  logic [63:0]            lsu_addr_i,
    input  logic                   lsu_we_i,
    input  logic [7:0]             lsu_be_i,
    input  logic [63:0]            lsu_wdata_i,
    input  logic                   lsu_kill_i,
    output logic                   lsu_resp_valid_o,
    output logic                   lsu_resp_we_o,
    output logic [63:0]            lsu_resp_rdata_o,
    output logic [INDEX_WIDTH-1:0] data_if_address_index_o,
    output logic [TAG_WIDTH-1:0]   data_if_address_tag_o,
    output logic [63:0]            data_if_data_wdata_o,
    output logic                   data_if_data_req_o,
    output logic                   data_if_data_we_o,
    output logic [7:0]             data_if_data_be_o,
    output logic                   data_if_kill_req_o,
    output logic                   data_if_tag_valid_o,
    input  logic                   data_if_data_gnt_i,
    input  logic                   data_if_data_rvalid_i,
    input  logic [63:0]            data_if_data_rdata_i,
    output logic                   err_o
);

    localparam int unsigned ADDR_W = INDEX_WIDTH + TAG_WIDTH;
    localparam int unsigned PTR_W  = (NR_OUTSTANDING > 1) ? $clog2(NR_OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(NR_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NR_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NR_OUTSTANDING - 1);

    logic                      issue_valid_q;
    logic [ADDR_W-1:0]         issue_addr_q;
    logic                      issue_we_q;
    logic [7:0]                issue_be_q;
    logic [63:0]               issue_wdata_q;

    logic                      tag_valid_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic                      tag_we_q;
    logic [PTR_W-1:0]          tag_idx_q;

    logic [NR_OUTSTANDING-1:0] fifo_we_q;
    logic [NR_OUTSTANDING-1:0] fifo_killed_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [CNT_W-1:0]          count_q;

    logic                      resp_valid_q;
    logic                      resp_we_q;
    logic [63:0]               resp_rdata_q;
    logic                      err_q;

    logic                      data_req;
    logic                      grant;
    logic                      accept;
    logic                      kill_now;
    logic                      pop;
    logic                      head_killed;
    logic                      unused_upper_addr;

    // Pointer increment that wraps at the FIFO depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_upper_addr = ^lsu_addr_i[63:ADDR_W];

    assign data_req        = issue_valid_q & (count_q < MAX_CNT);
    assign grant           = data_req & data_if_data_gnt_i;
    assign lsu_req_ready_o = ~rst_i & (~issue_valid_q | grant);
    assign accept          = lsu_req_valid_i & lsu_req_ready_o;
    assign kill_now        = tag_valid_q & ~tag_we_q & lsu_kill_i;
    assign pop             = data_if_data_rvalid_i & (count_q != '0);
    assign head_killed     = fifo_killed_q[rd_ptr_q] | (kill_now & (tag_idx_q == rd_ptr_q));

    assign data_if_data_req_o      = data_req;
    assign data_if_address_index_o = issue_addr_q[INDEX_WIDTH-1:0];
    assign data_if_data_we_o       = issue_we_q;
    assign data_if_data_be_o       = issue_be_q;
    assign data_if_data_wdata_o    = issue_wdata_q;
    assign data_if_address_tag_o   = tag_q;
    assign data_if_tag_valid_o     = tag_valid_q & ~kill_now;
    assign data_if_kill_req_o      = kill_now;
    assign lsu_resp_valid_o        = resp_valid_q;
    assign lsu_resp_we_o           = resp_we_q;
    assign lsu_resp_rdata_o        = resp_rdata_q;
    assign err_o                   = err_q;

    // Issue stage: capture an accepted op, hold it stable until it is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            issue_valid_q <= 1'b0;
            issue_addr_q  <= '0;
            issue_we_q    <= 1'b0;
            issue_be_q    <= '0;
            issue_wdata_q <= '0;
        end else if (accept) begin
            issue_valid_q <= 1'b1;
            issue_addr_q  <= lsu_addr_i[ADDR_W-1:0];
            issue_we_q    <= lsu_we_i;
            issue_be_q    <= lsu_be_i;
            issue_wdata_q <= lsu_wdata_i;
        end else if (grant) begin
            issue_valid_q <= 1'b0;
        end
    end

    // Tag stage: lives for exactly the cycle after a grant, remembers its FIFO slot for kills.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
            tag_we_q    <= 1'b0;
            tag_idx_q   <= '0;
        end else begin
            tag_valid_q <= grant;
            if (grant) begin
                tag_q     <= issue_addr_q[ADDR_W-1:INDEX_WIDTH];
                tag_we_q  <= issue_we_q;
                tag_idx_q <= wr_ptr_q;
            end
        end
    end

    // Outstanding FIFO: push on grant, mark the tag-stage slot on kill, pop on rvalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_we_q     <= '0;
            fifo_killed_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            if (grant) begin
                fifo_we_q[wr_ptr_q]     <= issue_we_q;
                fifo_killed_q[wr_ptr_q] <= 1'b0;
                wr_ptr_q                <= ptr_inc(wr_ptr_q);
            end
            if (kill_now) begin
                fifo_killed_q[tag_idx_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (grant && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!grant && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Response register: one-cycle pulse per popped, non-killed entry; stray rvalid sets sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= pop & ~head_killed;
            if (pop) begin
                resp_we_q    <= fifo_we_q[rd_ptr_q];
                resp_rdata_q <= data_if_data_rdata_i;
            end
            if (data_if_data_rvalid_i && count_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
